vga_line_feeder: RTL and testbench
==================================

// Module: vga_line_feeder
// PURPOSE
//  Pixel supplier directly upstream of the VGA timing generator. Buffers 12-bit pixels
//  (BLU[11:8] GRN[7:4] RED[3:0]) from the capture/processing path in a single-clock FIFO.
//  Returns one pixel per ReadMem strobe on ROWdata and pulses SyncVsync to restart VGA
//  timing once a frame start is buffered. Shares clk with the VGA block.
// PARAMETERS
//  DEPTH        1024    FIFO entries, power of 2, >= 640 (one active line)
//  PRIME_LEVEL  640     entries required in FILL before SyncVsync is issued, 1..DEPTH
//  UFLOW_COLOR  12'h00F colour driven on ROWdata for a read from an empty FIFO
// PORTS
//  clk         in   1   pixel clock
//  rstn        in   1   asynchronous active-low reset
//  s_valid     in   1   upstream pixel valid
//  s_ready     out  1   feeder accepts s_data this cycle
//  s_data      in   12  upstream pixel {B,G,R}
//  s_sof       in   1   qualifies s_data as first pixel of a frame
//  ReadMem     in   1   pixel request from VGA, one pixel per high cycle
//  ROWdata     out  12  pixel returned to VGA
//  SyncVsync   out  1   one-cycle pulse, restarts VGA counters
//  level       out  log2(DEPTH)+1  current FIFO occupancy
//  underflow   out  1   sticky: a read found the FIFO empty; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0 (ROWdata=12'h000, s_ready=0, level=0); FSM=IDLE, FIFO empty.
//  Transfer rule: write when s_valid && s_ready; s_ready = (state!=FLUSH) && !full.
//  FSM:
//   IDLE : s_ready=!full; pixels with s_sof=0 are accepted and discarded. sof pixel is
//          written -> FILL.
//   FILL : writes accepted; when level >= PRIME_LEVEL -> RUN, SyncVsync=1 that cycle only.
//   RUN  : normal. s_sof pixels are written like any other (frames back-to-back).
//          Read of empty FIFO -> FLUSH.
//   FLUSH: one cycle; s_ready=0; FIFO pointers and level cleared -> IDLE.
//  Read: ReadMem high at cycle t pops head; ROWdata valid at t+1 and held until next pop.
//   ReadMem outside RUN: no pop, ROWdata unchanged.
//  Underflow (RUN, ReadMem, empty): ROWdata<=UFLOW_COLOR at t+1, underflow<=1, ->FLUSH.
//   Empty FIFO does not bypass a same-cycle write; that is still underflow.
//  Full with simultaneous pop: s_ready stays 0 (no write-through); level = level-1.
//  Simultaneous push+pop, not full/empty: level unchanged; pointers wrap mod DEPTH.
//  level is the registered occupancy after the previous edge.
//   Widths: pointers log2(DEPTH) bits; level log2(DEPTH)+1 bits, never exceeds DEPTH.
//  Upstream stalls are absorbed; VGA never stalls. Sustained rate below one pixel per
//   visible ReadMem ends in underflow + resync, never in lost alignment.
//  rstn asserted mid-frame: immediate return to reset state; buffered pixels are lost.
// CONFIGURATION
//  FEED_STATS_EN defined: adds output uflow_cnt[15:0], +1 on each underflow event,
//   saturates at 16'hFFFF, reset 0; adds output frames_cnt[15:0], +1 on each SyncVsync,
//   wraps.
//  Not defined: neither port exists; no counter logic is synthesized.
// STRUCTURE
//  Package vga_feed_pkg: PIX_W=12; state enum {IDLE,FILL,RUN,FLUSH}; default UFLOW_COLOR.
//  Sub-module sync_fifo (DEPTH, WIDTH=PIX_W): registered-output RAM FIFO.
//   Signals: push, pop, flush, full, empty, level.
//   The FSM, SyncVsync and underflow logic live in vga_line_feeder.
// TESTING
//  1 Reset then s_valid=1, s_sof=0 x20 -> all accepted and dropped, level=0, state IDLE.
//  2 sof + 639 px, PRIME_LEVEL=640 -> SyncVsync single pulse on cycle level hits 640.
//  3 RUN, ReadMem 640 cycles, upstream 1 px/clk -> ROWdata seq matches input, 1-cyc lat.
//  4 Upstream stops, ReadMem continues past empty -> ROWdata=12'h00F, underflow=1, FLUSH
//    1 cycle (s_ready=0), then IDLE with level=0.
//  5 Fill to DEPTH=1024 -> s_ready=0; ReadMem 1 cycle -> level 1023, s_ready=1 next cycle.
//  6 FEED_STATS_EN: force 3 underflows -> uflow_cnt=3, frames_cnt=number of SyncVsync.
//    rstn low mid-RUN -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/vga_feed_pkg.sv
// Shared types and defaults for the VGA line feeder.
// The optional FEED_STATS_EN build adds statistics counters to the top level.
package vga_feed_pkg;

  localparam int PIX_W = 12;
  localparam logic [PIX_W-1:0] UFLOW_COLOR_DEF = 12'h00F;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } feed_state_e;

  typedef struct packed {
    logic push;
    logic pop;
    logic flush;
  } fifo_ctl_t;

endpackage

// File: rtl/vga_line_feeder_fifo.sv
// Single-clock RAM FIFO with a registered read port.
// dout updates only on pop and holds otherwise; flush clears pointers and occupancy.
module sync_fifo
  import vga_feed_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WIDTH = PIX_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             wr_en, rd_en;

  assign full  = (level == DEPTH_L);
  assign empty = (level == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  // Pointers are AW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      dout  <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/vga_line_feeder.sv
// Pixel buffer in front of the VGA timing generator: primes a FIFO from a frame start,
// then serves one pixel per ReadMem. Define FEED_STATS_EN for uflow_cnt/frames_cnt.
module vga_line_feeder
  import vga_feed_pkg::*;
#(
  parameter int         DEPTH       = 1024,
  parameter int         PRIME_LEVEL = 640,
  parameter logic [PIX_W-1:0] UFLOW_COLOR = UFLOW_COLOR_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIX_W-1:0]       s_data,
  input  logic                   s_sof,
  input  logic                   ReadMem,
  output logic [PIX_W-1:0]       ROWdata,
  output logic                   SyncVsync,
  output logic [$clog2(DEPTH):0] level,
  output logic                   underflow
`ifdef FEED_STATS_EN
  ,
  output logic [15:0]            uflow_cnt,
  output logic [15:0]            frames_cnt
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LEVEL);

  feed_state_e state, state_nxt;
  fifo_ctl_t   ctl;
  pix_t        fifo_dout;
  logic        full, empty;
  logic        accept, uf_ev, uf_sel;

  // rstn gates s_ready so the handshake is closed while reset is held.
  assign s_ready = rstn && (state != FLUSH) && !full;
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_nxt = state;
    ctl       = '0;
    SyncVsync = 1'b0;
    uf_ev     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && s_sof) begin
          ctl.push  = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        ctl.push = accept;
        if (level >= PRIME_L) begin
          SyncVsync = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        ctl.push = accept;
        // A same-cycle write is not bypassed to an empty read.
        if (ReadMem) begin
          if (empty) begin
            uf_ev     = 1'b1;
            state_nxt = FLUSH;
          end else begin
            ctl.pop = 1'b1;
          end
        end
      end
      FLUSH: begin
        ctl.flush = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      uf_sel    <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (uf_ev) begin
        uf_sel    <= 1'b1;
        underflow <= 1'b1;
      end else if (ctl.pop) begin
        uf_sel <= 1'b0;
      end
    end
  end

  assign ROWdata = uf_sel ? UFLOW_COLOR : fifo_dout;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (ctl.push),
    .pop   (ctl.pop),
    .flush (ctl.flush),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef FEED_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      uflow_cnt  <= '0;
      frames_cnt <= '0;
    end else begin
      if (uf_ev && (uflow_cnt != 16'hFFFF)) uflow_cnt <= uflow_cnt + 16'd1;
      if (SyncVsync) frames_cnt <= frames_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_line_feeder.sv
// Self-checking bench for vga_line_feeder: vector table, directed corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.
module tb_vga_line_feeder;

  localparam int DEPTH = 1024;
  localparam int PRIME = 640;
  localparam logic [11:0] UFC = 12'h00F;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        ReadMem = 1'b0;
  logic [11:0] s_data = '0;
  logic        s_ready, SyncVsync, underflow;
  logic [11:0] ROWdata;
  logic [10:0] level;
`ifdef FEED_STATS_EN
  logic [15:0] uflow_cnt, frames_cnt;
`endif

  always #5 clk = ~clk;

  vga_line_feeder #(
    .DEPTH       (DEPTH),
    .PRIME_LEVEL (PRIME),
    .UFLOW_COLOR (UFC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .ReadMem   (ReadMem),
    .ROWdata   (ROWdata),
    .SyncVsync (SyncVsync),
    .level     (level),
    .underflow (underflow)
`ifdef FEED_STATS_EN
    ,
    .uflow_cnt (uflow_cnt),
    .frames_cnt(frames_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: buffered pixels as a queue, mode 0 idle, 1 fill, 2 run, 3 flush.
  logic [11:0] mq[$];
  int          m_mode;
  logic [11:0] m_row;
  bit          m_uf;
  int          m_ufcnt, m_frames;
  int          sync_seen;

  typedef struct {
    bit          v;
    bit          sof;
    bit          rm;
    logic [11:0] d;
    logic [10:0] exp_level;
    bit          exp_ready;
  } vec_t;
  vec_t tbl[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_mode = 0;
    m_row = '0;
    m_uf = 0;
    m_ufcnt = 0;
    m_frames = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ROWdata", ROWdata, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_SyncVsync", SyncVsync, 0);
    chk("rst_level", level, 0);
    chk("rst_underflow", underflow, 0);
`ifdef FEED_STATS_EN
    chk("rst_uflow_cnt", uflow_cnt, 0);
    chk("rst_frames_cnt", frames_cnt, 0);
`endif
  endtask

  task automatic do_reset();
    s_valid = 0; s_sof = 0; ReadMem = 0; s_data = '0;
    rstn = 0;
    model_reset();
    #2;
    chk_reset_outputs();
    @(negedge clk);
    rstn = 1;
  endtask

  // One clock: drive inputs, compare DUT against model before the edge, then advance model.
  task automatic cycle(input bit v, input logic [11:0] d, input bit sof, input bit rm);
    bit rdy, syn, acc, pop, uev;
    @(posedge clk);
    #1;
    s_valid = v; s_data = d; s_sof = sof; ReadMem = rm;
    #3;
    rdy = (m_mode != 3) && (mq.size() < DEPTH);
    syn = (m_mode == 1) && (mq.size() >= PRIME);
    chk("s_ready", s_ready, rdy);
    chk("SyncVsync", SyncVsync, syn);
    chk("level", level, mq.size());
    chk("ROWdata", ROWdata, m_row);
    chk("underflow", underflow, m_uf);
`ifdef FEED_STATS_EN
    chk("uflow_cnt", uflow_cnt, m_ufcnt);
    chk("frames_cnt", frames_cnt, m_frames);
`endif
    if (SyncVsync === 1'b1) sync_seen++;
    acc = v && rdy;
    pop = (m_mode == 2) && rm && (mq.size() > 0);
    uev = (m_mode == 2) && rm && (mq.size() == 0);
    if (pop) m_row = mq.pop_front();
    case (m_mode)
      0: if (acc && sof) begin mq.push_back(d); m_mode = 1; end
      1: begin
        if (acc) mq.push_back(d);
        if (syn) begin m_mode = 2; m_frames = (m_frames + 1) & 16'hFFFF; end
      end
      2: begin
        if (acc) mq.push_back(d);
        if (uev) begin
          m_mode = 3; m_row = UFC; m_uf = 1;
          if (m_ufcnt < 65535) m_ufcnt++;
        end
      end
      default: begin mq.delete(); m_mode = 0; end
    endcase
  endtask

  initial begin
    do_reset();

    // Table: non-sof pixels dropped in IDLE, then a frame start begins filling.
    for (int i = 0; i < 24; i++) begin
      tbl[i].v = (i < 23);
      tbl[i].sof = (i == 20);
      tbl[i].rm = 0;
      tbl[i].d = 12'(i * 37 + 5);
      tbl[i].exp_level = (i <= 20) ? 11'd0 : 11'(i - 20);
      tbl[i].exp_ready = 1;
    end
    sync_seen = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].sof, tbl[i].rm);
      chk("tbl_level", level, tbl[i].exp_level);
      chk("tbl_s_ready", s_ready, tbl[i].exp_ready);
    end

    // Prime to 640 entries: exactly one SyncVsync.
    for (int i = 0; i < PRIME - 3; i++) cycle(1, 12'($urandom), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 12'h0, 0, 0);
    chk("sync_pulses", sync_seen, 1);

    // Steady streaming, then upstream stops and reads run past empty.
    for (int i = 0; i < 640; i++) cycle(1, 12'($urandom), 0, 1);
    for (int i = 0; i < 700; i++) cycle(0, 12'h0, 0, 1);
    chk("uf_flag", underflow, 1);
    chk("uf_rowdata", ROWdata, UFC);
    chk("uf_level", level, 0);
    chk("uf_idle_ready", s_ready, 1);

    // Fill to DEPTH, then a single pop frees one slot.
    cycle(1, 12'h5A5, 1, 0);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1, 12'($urandom), 0, 0);
    cycle(1, 12'h123, 0, 0);
    chk("full_ready", s_ready, 0);
    chk("full_level", level, DEPTH);
    cycle(1, 12'h456, 0, 1);
    cycle(0, 12'h0, 0, 0);
    chk("pop_level", level, DEPTH - 1);
    chk("pop_ready", s_ready, 1);

    // Three deterministic frame/underflow rounds from a fresh reset.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      cycle(1, 12'($urandom), 1, 0);
      for (int i = 0; i < PRIME - 1; i++) cycle(1, 12'($urandom), 0, 0);
      for (int i = 0; i < 2; i++) cycle(0, 12'h0, 0, 0);
      for (int i = 0; i < 645; i++) cycle(0, 12'h0, 0, 1);
    end
`ifdef FEED_STATS_EN
    chk("stats_uflow3", uflow_cnt, 3);
    chk("stats_frames3", frames_cnt, 3);
`endif

    // Randomized traffic with alternating write pressure.
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 500; i++) begin
        cycle(($urandom_range(99) < ((blk % 2) ? 40 : 92)),
              12'($urandom), ($urandom_range(39) == 0), ($urandom_range(99) < 70));
      end
    end

    // Asynchronous reset in the middle of RUN.
    cycle(1, 12'($urandom), 1, 0);
    for (int i = 0; i < PRIME + 5; i++) cycle(1, 12'($urandom), ($urandom_range(9) == 0), 0);
    for (int i = 0; i < 10; i++) cycle(1, 12'($urandom), 0, 1);
    @(posedge clk);
    #2;
    s_valid = 0; s_sof = 0; ReadMem = 0;
    rstn = 0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 8; i++) cycle(1, 12'($urandom), (i == 2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
